ec_point_mult: RTL and testbench

Scalar point multiplier: computes Q = k·P over a prime curve in Jacobian coordinates using left-to-right double-and-add. It sits directly upstream of `ec_point_add` and a companion point-doubling unit. It feeds operand pairs to each unit over valid/ready handshakes and consumes their results. One multiplication is in flight at a time, and the result goes to the downstream consumer (e.g. affine conversion).

---
 rtl/ec_point_mult_pkg.sv | 15 +
 rtl/ec_point_mult.sv | 200 ++++++++++++++++++++
 tb/tb_ec_point_mult.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ec_point_mult_pkg.sv
// Curve package shared by the point arithmetic blocks: field element and
// Jacobian point types plus the field width.
package ec_point_mult_pkg;

  localparam int FIELD_BITS = 256;

  typedef logic [FIELD_BITS-1:0] fe_t;

  typedef struct packed {
    fe_t x;
    fe_t y;
    fe_t z;
  } jpoint_t;

endpackage

// File: rtl/ec_point_mult.sv
// Scalar point multiplier Q = k*P, left-to-right double-and-add. Doubling and
// addition are delegated to external units over valid/ready handshakes.
module ec_point_mult
  import ec_point_mult_pkg::*;
#(
  parameter type FE_TYPE  = fe_t,
  parameter type FP_TYPE  = jpoint_t,
  parameter int  DAT_BITS = FIELD_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [DAT_BITS-1:0] i_k,
  input  FP_TYPE              i_p,
  input  logic                i_val,
  output logic                o_rdy,
  output FP_TYPE              o_p,
  output logic                o_val,
  input  logic                i_rdy,
  output logic                o_err,
  output FP_TYPE              o_dbl_p,
  output logic                o_dbl_val,
  input  logic                i_dbl_rdy,
  input  FP_TYPE              i_dbl_p,
  input  logic                i_dbl_val,
  input  logic                i_dbl_err,
  output logic                o_dbl_rdy,
  output FP_TYPE              o_add_p1,
  output FP_TYPE              o_add_p2,
  output logic                o_add_val,
  input  logic                i_add_rdy,
  input  FP_TYPE              i_add_p,
  input  logic                i_add_val,
  input  logic                i_add_err,
  output logic                o_add_rdy
);

  localparam int IDX_W = (DAT_BITS > 1) ? $clog2(DAT_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_BIT, S_DBL_REQ, S_DBL_WAIT, S_ADD_REQ, S_ADD_WAIT, S_ADV, S_DONE
  } state_t;

  state_t              state, state_n;
  FP_TYPE              q, q_n, p_l, p_l_n, res_n;
  logic [DAT_BITS-1:0] k_l, k_l_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic                val_n, err_n;

  // Next-state and datapath update; every output is registered from these.
  always_comb begin
    state_n = state;
    q_n     = q;
    p_l_n   = p_l;
    k_l_n   = k_l;
    idx_n   = idx;
    res_n   = o_p;
    val_n   = o_val;
    err_n   = o_err;
    case (state)
      S_IDLE: begin
        if (i_val && o_rdy) begin
          k_l_n = i_k;
          p_l_n = i_p;
          q_n   = '0;
          idx_n = IDX_W'(DAT_BITS - 1);
          if (i_k == '0 || i_p.z == FE_TYPE'(0)) begin
            res_n   = '0;
            val_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            state_n = S_BIT;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_BIT: begin
        // Doubling infinity yields infinity, so only load P on a set bit.
        if (q.z == FE_TYPE'(0)) begin
          if (k_l[idx]) begin
            q_n = p_l;
          end else begin
            q_n = q;
          end
          state_n = S_ADV;
        end else begin
          state_n = S_DBL_REQ;
        end
      end
      S_DBL_REQ: begin
        if (i_dbl_rdy) begin
          state_n = S_DBL_WAIT;
        end else begin
          state_n = S_DBL_REQ;
        end
      end
      S_DBL_WAIT: begin
        if (i_dbl_val) begin
          q_n = i_dbl_p;
          if (i_dbl_err) begin
            err_n   = 1'b1;
            res_n   = i_dbl_p;
            val_n   = 1'b1;
            state_n = S_DONE;
          end else if (k_l[idx]) begin
            state_n = S_ADD_REQ;
          end else begin
            state_n = S_ADV;
          end
        end else begin
          state_n = S_DBL_WAIT;
        end
      end
      S_ADD_REQ: begin
        if (i_add_rdy) begin
          state_n = S_ADD_WAIT;
        end else begin
          state_n = S_ADD_REQ;
        end
      end
      S_ADD_WAIT: begin
        if (i_add_val) begin
          q_n = i_add_p;
          if (i_add_err) begin
            err_n   = 1'b1;
            res_n   = i_add_p;
            val_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            state_n = S_ADV;
          end
        end else begin
          state_n = S_ADD_WAIT;
        end
      end
      S_ADV: begin
        if (idx == '0) begin
          res_n   = q;
          val_n   = 1'b1;
          state_n = S_DONE;
        end else begin
          idx_n   = idx - IDX_W'(1);
          state_n = S_BIT;
        end
      end
      S_DONE: begin
        if (i_rdy) begin
          val_n   = 1'b0;
          err_n   = 1'b0;
          state_n = S_IDLE;
        end else begin
          state_n = S_DONE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; handshake flags decode the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      q         <= '0;
      p_l       <= '0;
      k_l       <= '0;
      idx       <= '0;
      o_rdy     <= 1'b0;
      o_p       <= '0;
      o_val     <= 1'b0;
      o_err     <= 1'b0;
      o_dbl_p   <= '0;
      o_dbl_val <= 1'b0;
      o_dbl_rdy <= 1'b0;
      o_add_p1  <= '0;
      o_add_p2  <= '0;
      o_add_val <= 1'b0;
      o_add_rdy <= 1'b0;
    end else begin
      state     <= state_n;
      q         <= q_n;
      p_l       <= p_l_n;
      k_l       <= k_l_n;
      idx       <= idx_n;
      o_rdy     <= (state_n == S_IDLE);
      o_p       <= res_n;
      o_val     <= val_n;
      o_err     <= err_n;
      o_dbl_p   <= q_n;
      o_dbl_val <= (state_n == S_DBL_REQ);
      o_dbl_rdy <= (state_n == S_DBL_WAIT);
      o_add_p1  <= q_n;
      o_add_p2  <= p_l_n;
      o_add_val <= (state_n == S_ADD_REQ);
      o_add_rdy <= (state_n == S_ADD_WAIT);
    end
  end

endmodule

// File: tb/tb_ec_point_mult.sv
// Bench for ec_point_mult: a point with z=1 and x=n stands for nP, so the
// expected result of k*P is simply x = k*n, checked by a per-cycle monitor.
module tb_ec_point_mult;
  import ec_point_mult_pkg::*;

  localparam int DB = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [DB-1:0] i_k;
  jpoint_t       i_p, o_p, o_dbl_p, i_dbl_p, o_add_p1, o_add_p2, i_add_p;
  logic          i_val, o_rdy, o_val, i_rdy, o_err;
  logic          o_dbl_val, i_dbl_rdy, i_dbl_val, i_dbl_err, o_dbl_rdy;
  logic          o_add_val, i_add_rdy, i_add_val, i_add_err, o_add_rdy;

  int      checks = 0;
  int      errors = 0;
  int      dbl_reqs, add_reqs, add_err_at;
  jpoint_t exp_p;
  logic    exp_err;

  ec_point_mult #(.FE_TYPE(fe_t), .FP_TYPE(jpoint_t), .DAT_BITS(DB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_k(i_k), .i_p(i_p), .i_val(i_val),
    .o_rdy(o_rdy), .o_p(o_p), .o_val(o_val), .i_rdy(i_rdy), .o_err(o_err),
    .o_dbl_p(o_dbl_p), .o_dbl_val(o_dbl_val), .i_dbl_rdy(i_dbl_rdy),
    .i_dbl_p(i_dbl_p), .i_dbl_val(i_dbl_val), .i_dbl_err(i_dbl_err),
    .o_dbl_rdy(o_dbl_rdy), .o_add_p1(o_add_p1), .o_add_p2(o_add_p2),
    .o_add_val(o_add_val), .i_add_rdy(i_add_rdy), .i_add_p(i_add_p),
    .i_add_val(i_add_val), .i_add_err(i_add_err), .o_add_rdy(o_add_rdy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [767:0] act, input logic [767:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  function automatic jpoint_t mk(input int unsigned x, input int unsigned y, input int unsigned z);
    jpoint_t r = '0;
    r.x = fe_t'(x);
    r.y = fe_t'(y);
    r.z = fe_t'(z);
    return r;
  endfunction

  function automatic jpoint_t model_mult(input logic [DB-1:0] k, input jpoint_t p);
    jpoint_t r = '0;
    if (k == '0 || p.z == '0) return r;
    if (k == 1) return p;
    r.x = fe_t'(k) * p.x;
    r.y = fe_t'(1);
    r.z = fe_t'(1);
    return r;
  endfunction

  function automatic int msb_pos(input logic [DB-1:0] k);
    for (int b = DB - 1; b >= 0; b--) if (k[b]) return b;
    return 0;
  endfunction

  // Reference units: doubler returns x=2n, adder x=n1+n2, roughly 5 cycles each.
  initial begin : units
    jpoint_t dbl_arg, dbl_pend, add_a, add_b, add_pend_a, add_pend_b;
    logic dbl_busy, add_busy, dbl_req_f, dbl_rsp_f, add_req_f, add_rsp_f;
    int dbl_cnt, add_cnt;
    dbl_reqs = 0; add_reqs = 0;
    {i_dbl_rdy, i_dbl_val, i_dbl_err, i_add_rdy, i_add_val, i_add_err} = '0;
    i_dbl_p = '0; i_add_p = '0;
    {dbl_busy, add_busy, dbl_req_f, dbl_rsp_f, add_req_f, add_rsp_f} = '0;
    dbl_arg = '0; dbl_pend = '0; add_a = '0; add_b = '0; add_pend_a = '0; add_pend_b = '0;
    dbl_cnt = 0; add_cnt = 0;
    forever begin
      step();
      if (i_rst) begin
        {i_dbl_rdy, i_dbl_val, i_dbl_err, i_add_rdy, i_add_val, i_add_err} = '0;
        {dbl_busy, add_busy, dbl_req_f, dbl_rsp_f, add_req_f, add_rsp_f} = '0;
      end else begin
        if (dbl_rsp_f) begin dbl_busy = 1'b0; i_dbl_val = 1'b0; end
        if (dbl_req_f) begin dbl_busy = 1'b1; dbl_cnt = 5; dbl_arg = dbl_pend; dbl_reqs++; end
        if (dbl_busy && !i_dbl_val) begin
          dbl_cnt--;
          if (dbl_cnt == 0) begin
            i_dbl_val = 1'b1;
            i_dbl_p   = '0;
            i_dbl_p.x = dbl_arg.x << 1;
            i_dbl_p.y = fe_t'(1);
            i_dbl_p.z = fe_t'(1);
          end
        end
        if (add_rsp_f) begin add_busy = 1'b0; i_add_val = 1'b0; i_add_err = 1'b0; end
        if (add_req_f) begin add_busy = 1'b1; add_cnt = 5; add_a = add_pend_a; add_b = add_pend_b; add_reqs++; end
        if (add_busy && !i_add_val) begin
          add_cnt--;
          if (add_cnt == 0) begin
            i_add_val = 1'b1;
            i_add_err = (add_reqs == add_err_at);
            i_add_p   = '0;
            i_add_p.x = add_a.x + add_b.x;
            i_add_p.y = fe_t'(1);
            i_add_p.z = fe_t'(1);
          end
        end
        i_dbl_rdy  = !dbl_busy && ($urandom_range(0, 2) != 0);
        i_add_rdy  = !add_busy && ($urandom_range(0, 2) != 0);
        dbl_req_f  = o_dbl_val && i_dbl_rdy;
        dbl_pend   = o_dbl_p;
        dbl_rsp_f  = o_dbl_rdy && i_dbl_val;
        add_req_f  = o_add_val && i_add_rdy;
        add_pend_a = o_add_p1;
        add_pend_b = o_add_p2;
        add_rsp_f  = o_add_rdy && i_add_val;
      end
    end
  end

  // Per-cycle compare of result, hold behaviour and handshake exclusivity.
  initial begin : monitor
    logic    pv_val;
    jpoint_t pv_p;
    pv_val = 1'b0;
    pv_p   = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        pv_val = 1'b0;
      end else begin
        if (o_val) begin
          check("result_err", o_err, exp_err);
          if (!exp_err) check("result_p", o_p, exp_p);
        end
        if (pv_val && !i_rdy) begin
          check("hold_val", o_val, 1'b1);
          check("hold_p", o_p, pv_p);
        end
        check("rdy_val_exclusive", o_rdy & o_val, 1'b0);
        check("unit_req_exclusive", o_dbl_val & o_add_val, 1'b0);
        pv_val = o_val;
        pv_p   = o_p;
      end
    end
  end

  task automatic run_op(input logic [DB-1:0] k, input jpoint_t p, input int stall,
                        input logic add_err, input int lat_exp);
    int  lat, base_d, base_a, exp_d, exp_a, m;
    bit  fast;
    lat = 0;
    while (!o_rdy && lat < 50) begin step(); lat++; end
    check("req_ready", o_rdy, 1'b1);
    fast  = (k == '0) || (p.z == '0);
    m     = msb_pos(k);
    exp_d = fast ? 0 : m;
    exp_a = fast ? 0 : $countones(k) - 1;
    if (add_err) begin
      // Abort at the first add: doublings run from the MSB down to the next set bit.
      exp_a = 1;
      for (int b = m - 1; b >= 0; b--) if (k[b]) begin exp_d = m - b; break; end
    end
    exp_p      = model_mult(k, p);
    exp_err    = add_err;
    base_d     = dbl_reqs;
    base_a     = add_reqs;
    add_err_at = add_err ? add_reqs + 1 : -1;
    i_k = k; i_p = p; i_val = 1'b1;
    step();
    i_val = 1'b0;
    lat = 0;
    while (!o_val && lat < 3000) begin step(); lat++; end
    check("result_valid", o_val, 1'b1);
    if (lat_exp >= 0) check("latency", lat, lat_exp);
    repeat (stall) step();
    i_rdy = 1'b1;
    step();
    i_rdy = 1'b0;
    check("release_val", o_val, 1'b0);
    check("release_err", o_err, 1'b0);
    check("release_rdy", o_rdy, 1'b1);
    check("dbl_count", dbl_reqs - base_d, exp_d);
    check("add_count", add_reqs - base_a, exp_a);
  endtask

  initial begin : main
    int lat;
    logic [DB-1:0] rk;
    jpoint_t rp;
    i_rst = 1'b1; i_val = 1'b0; i_rdy = 1'b0; i_k = '0; i_p = '0;
    exp_p = '0; exp_err = 1'b0; add_err_at = -1;
    #1;
    check("reset_flags", {o_rdy, o_val, o_err, o_dbl_val, o_dbl_rdy, o_add_val, o_add_rdy}, 7'd0);
    check("reset_points", o_p | o_dbl_p | o_add_p1 | o_add_p2, 768'd0);
    repeat (2) step();
    i_rst = 1'b0;
    step();
    check("rdy_after_reset", o_rdy, 1'b1);

    check("model_pin_13", model_mult(8'd13, mk(1, 1, 1)), mk(13, 1, 1));
    check("model_pin_dbl13", msb_pos(8'd13), 3);
    check("model_pin_add13", $countones(8'd13) - 1, 2);

    run_op(8'd13, mk(1, 1, 1), 0, 1'b0, -1);
    check("mul13_x", o_p.x, fe_t'(13));
    run_op(8'd0, mk(5, 9, 1), 1, 1'b0, 0);
    run_op(8'd255, mk(3, 4, 0), 0, 1'b0, 0);
    run_op(8'd1, mk(77, 1234, 1), 10, 1'b0, 16);
    check("k1_passthrough", o_p, mk(77, 1234, 1));
    run_op(8'd3, mk(1, 1, 1), 2, 1'b1, -1);

    // Asynchronous reset while waiting on the doubler.
    lat = 0;
    while (!o_rdy && lat < 50) begin step(); lat++; end
    exp_p = model_mult(8'd200, mk(7, 1, 1)); exp_err = 1'b0; add_err_at = -1;
    i_k = 8'd200; i_p = mk(7, 1, 1); i_val = 1'b1;
    step();
    i_val = 1'b0;
    lat = 0;
    while (!o_dbl_rdy && lat < 200) begin step(); lat++; end
    check("reach_dbl_wait", o_dbl_rdy, 1'b1);
    #2 i_rst = 1'b1;
    #1;
    check("async_reset_flags", {o_rdy, o_val, o_err, o_dbl_val, o_dbl_rdy, o_add_val, o_add_rdy}, 7'd0);
    check("async_reset_points", o_p | o_dbl_p | o_add_p1 | o_add_p2, 768'd0);
    repeat (2) step();
    i_rst = 1'b0;
    run_op(8'd6, mk(1, 1, 1), 0, 1'b0, -1);
    check("mul6_x", o_p.x, fe_t'(6));

    for (int t = 0; t < 20; t++) begin
      rk = DB'($urandom_range(0, 255));
      rp = mk($urandom_range(1, 65535), $urandom_range(0, 65535),
              ($urandom_range(0, 7) == 0) ? 0 : 1);
      run_op(rk, rp, $urandom_range(0, 3), 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
